stim_mon: RTL
=============

STIM_MON -- requirements
Module: stim_mon

Interface
REQ-001 SHALL have parameter GAP_TIMEOUT, default 16383, giving the max inter-phase gap in cycles before a pulse closes as monophasic.
REQ-002 SHALL have port clk_i  input  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port anode_en_i, cathode_en_i  input  1 each  phase enables from the stimulator, synchronous to clk_i (no synchronizer).
REQ-005 SHALL have port mon_en_i  input  1  monitor enable; low clears the FSM and pulse count.
REQ-006 SHALL have port bal_chk_en_i  input  1  enables the charge-balance check.
REQ-007 SHALL have port max_phase_i  input  14  phase-length safety limit; 0 disables the check.
REQ-008 SHALL have port clear_err_i  input  1  clears the sticky error flags.
REQ-009 SHALL have port meas_wa_o, meas_wc_o, meas_gap_o  output  14 each  anodic width, cathodic width and gap of the last pulse.
REQ-010 SHALL have port meas_interval_o  output  16  idle cycles preceding the last pulse.
REQ-011 SHALL have port meas_pol_o  output  1  1 = first phase of the last pulse was anodic.
REQ-012 SHALL have port meas_valid_o  output  1  one-cycle strobe when the meas_* outputs update.
REQ-013 SHALL have port pulse_cnt_o  output  12  count of completed pulses since enable.
REQ-014 SHALL have port err_overlap_o, err_overlength_o, err_imbalance_o  output  1 each  sticky fault flags.

Function
REQ-015 Width SHALL be the number of sampled-high cycles; gap and interval SHALL be the number of cycles with both enables low.
REQ-016 FSM states SHALL be M_IDLE, M_PH1, M_GAP, M_PH2, M_INTERVAL.
REQ-017 M_IDLE/M_INTERVAL -> M_PH1 on the first cycle either enable is high; first-phase polarity SHALL be latched at that point.
REQ-018 M_PH1 -> M_GAP when the first-phase enable goes low.
REQ-019 M_PH1 -> M_PH2 directly when the opposite enable is high in the first low cycle; gap SHALL then be 0.
REQ-020 M_GAP -> M_PH2 on the opposite enable going high.
REQ-021 If the same-polarity enable rises in M_GAP, or the gap count reaches GAP_TIMEOUT, the pulse SHALL close as monophasic: absent width = 0, gap = 0, gap cycles carried into the interval count; same-polarity rise then enters M_PH1.
REQ-022 M_PH2 -> M_INTERVAL when the second-phase enable goes low.
REQ-023 meas_valid_o SHALL assert exactly one cycle, in the cycle after pulse close, with all meas_* outputs registered and updated in that same cycle.
REQ-024 meas_interval_o SHALL be 0 for the first pulse after mon_en_i rises.
REQ-025 Width and gap counters SHALL saturate at 14'h3FFF; the interval counter SHALL saturate at 16'hFFFF.
REQ-026 pulse_cnt_o SHALL increment on each meas_valid_o and wrap from 12'hFFF to 0.
REQ-027 Both enables high in any cycle SHALL set err_overlap_o and force M_IDLE; the current pulse SHALL be discarded with no meas_valid_o.
REQ-028 A phase count reaching max_phase_i (non-zero) while the enable is still high SHALL set err_overlength_o in that cycle; measurement SHALL continue.
REQ-029 With bal_chk_en_i=1, a biphasic pulse with wa != wc SHALL set err_imbalance_o together with meas_valid_o; monophasic pulses are exempt.
REQ-030 clear_err_i SHALL clear all flags; a simultaneous set SHALL win over clear.
REQ-031 mon_en_i=0 SHALL force M_IDLE and clear counters and pulse_cnt_o; meas_* outputs and error flags SHALL hold their values.

Reset
REQ-032 reset_n_i low SHALL asynchronously force M_IDLE and set every output and counter to 0.
REQ-033 Reset asserted mid-pulse SHALL discard that pulse; after release, the first measured pulse SHALL start at the next enable rise seen from M_IDLE.

Structure
REQ-034 Package stim_pkg SHALL hold width constants (W_PULSE=14, W_INTERVAL=16, W_NUM=12) and the FSM state encodings.
REQ-035 Saturating counting SHALL use one sub-module, stim_satcnt (parameterized width, clear, enable), instantiated for the phase, gap and interval counters.

Verification
REQ-036 Anode 5, gap 3, cathode 5 -> meas_wa=5, gap=3, wc=5, pol=1, interval=0, one meas_valid, pulse_cnt=1.
REQ-037 Repeat the pulse after 10 idle cycles -> meas_interval=10, pulse_cnt=2.
REQ-038 Cathode 4 then anode 6 immediately, bal_chk_en=1 -> gap=0, pol=0, err_imbalance=1 in the meas_valid cycle.
REQ-039 Cathode 7, then idle for GAP_TIMEOUT cycles -> meas_valid with wc=7, wa=0, gap=0.
REQ-040 max_phase=8, anode 10 cycles -> err_overlength rises on the 8th high cycle, meas_wa=10.
REQ-041 Both enables high in PH1 -> err_overlap=1, no meas_valid, FSM in M_IDLE; clear_err_i -> flag clears.

Source files
------------

// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared widths and FSM encoding for the stimulation pulse monitor
package stim_pkg;

  localparam int W_PULSE    = 14;
  localparam int W_INTERVAL = 16;
  localparam int W_NUM      = 12;

  typedef enum logic [2:0] {
    M_IDLE     = 3'd0,
    M_PH1      = 3'd1,
    M_GAP      = 3'd2,
    M_PH2      = 3'd3,
    M_INTERVAL = 3'd4
  } mon_state_e;

endpackage

// File: rtl/stim_mon_if.sv
// rtl/stim_mon_if.sv - phase-enable inputs and pulse measurement bundle of the monitor
interface stim_mon_if;
  import stim_pkg::*;

  logic                  anode_en;
  logic                  cathode_en;
  logic [W_PULSE-1:0]    meas_wa;
  logic [W_PULSE-1:0]    meas_wc;
  logic [W_PULSE-1:0]    meas_gap;
  logic [W_INTERVAL-1:0] meas_interval;
  logic                  meas_pol;
  logic                  meas_valid;

  modport master (
    output anode_en, cathode_en,
    input  meas_wa, meas_wc, meas_gap, meas_interval, meas_pol, meas_valid
  );

  modport slave (
    input  anode_en, cathode_en,
    output meas_wa, meas_wc, meas_gap, meas_interval, meas_pol, meas_valid
  );

endinterface

// File: rtl/stim_satcnt.sv
// rtl/stim_satcnt.sv - saturating up-counter; clear together with enable restarts at 1
module stim_satcnt #(
  parameter int W = 14
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = en_i ? W'(1) : '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stim_mon.sv
// rtl/stim_mon.sv - measures biphasic stimulation pulses (widths, gap, interval) and flags faults
module stim_mon
  import stim_pkg::*;
#(
  parameter int GAP_TIMEOUT = 16383
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  anode_en_i,
  input  logic                  cathode_en_i,
  input  logic                  mon_en_i,
  input  logic                  bal_chk_en_i,
  input  logic [W_PULSE-1:0]    max_phase_i,
  input  logic                  clear_err_i,
  output logic [W_PULSE-1:0]    meas_wa_o,
  output logic [W_PULSE-1:0]    meas_wc_o,
  output logic [W_PULSE-1:0]    meas_gap_o,
  output logic [W_INTERVAL-1:0] meas_interval_o,
  output logic                  meas_pol_o,
  output logic                  meas_valid_o,
  output logic [W_NUM-1:0]      pulse_cnt_o,
  output logic                  err_overlap_o,
  output logic                  err_overlength_o,
  output logic                  err_imbalance_o
);

  mon_state_e            state_q, state_d;
  logic                  pol_q;
  logic [W_PULSE-1:0]    w1_q;
  logic [W_INTERVAL-1:0] int_lat_q;
  logic [W_PULSE-1:0]    ph_cnt, gap_cnt, ph_nxt, w2;
  logic [W_INTERVAL-1:0] int_cnt;
  logic                  both, any_en, first_en, second_en, gap_expire;
  logic                  start, enter_ph2, close_bi, close_mono, close, w1_ld;
  logic                  ph_clr, ph_en, gap_clr, gap_en, int_clr, int_en;
  logic                  set_overlap, set_overlength, set_imbalance;

  assign both       = anode_en_i & cathode_en_i;
  assign any_en     = anode_en_i | cathode_en_i;
  assign first_en   = pol_q ? anode_en_i : cathode_en_i;
  assign second_en  = pol_q ? cathode_en_i : anode_en_i;
  assign gap_expire = ({1'b0, gap_cnt} + 15'd1) == 15'(GAP_TIMEOUT);

  always_comb begin
    state_d = state_q;
    start = 1'b0; enter_ph2 = 1'b0; close_bi = 1'b0; close_mono = 1'b0; w1_ld = 1'b0;
    ph_clr = 1'b0; ph_en = 1'b0; gap_clr = 1'b0; gap_en = 1'b0;
    int_clr = 1'b0; int_en = 1'b0; set_overlap = 1'b0;
    if (!mon_en_i) begin
      state_d = M_IDLE;
      ph_clr = 1'b1; gap_clr = 1'b1; int_clr = 1'b1;
    end else if (both) begin
      set_overlap = 1'b1;
      state_d = M_IDLE;
      ph_clr = 1'b1; gap_clr = 1'b1; int_clr = 1'b1;
    end else begin
      case (state_q)
        M_IDLE, M_INTERVAL: begin
          if (any_en) start = 1'b1;
          else        int_en = (state_q == M_INTERVAL);
        end
        M_PH1: begin
          if (first_en) begin
            ph_en = 1'b1;
          end else begin
            w1_ld = 1'b1;
            if (second_en) begin
              enter_ph2 = 1'b1;
            end else begin
              state_d = M_GAP;
              gap_en = 1'b1; int_en = 1'b1;
            end
          end
        end
        M_GAP: begin
          if (second_en) begin
            enter_ph2 = 1'b1;
          end else if (first_en) begin
            close_mono = 1'b1; start = 1'b1;
          end else begin
            // Gap cycles also run the interval counter so a timed-out gap counts as idle time.
            gap_en = 1'b1; int_en = 1'b1;
            if (gap_expire) begin
              close_mono = 1'b1;
              state_d = M_INTERVAL;
            end
          end
        end
        M_PH2: begin
          if (second_en) begin
            ph_en = 1'b1;
          end else begin
            close_bi = 1'b1;
            if (first_en) start = 1'b1;
            else begin
              state_d = M_INTERVAL;
              int_en = 1'b1;
            end
          end
        end
        default: state_d = M_IDLE;
      endcase
      if (start) begin
        state_d = M_PH1;
        ph_clr = 1'b1; ph_en = 1'b1; gap_clr = 1'b1; int_clr = 1'b1;
      end
      if (enter_ph2) begin
        state_d = M_PH2;
        ph_clr = 1'b1; ph_en = 1'b1; int_clr = 1'b1;
      end
    end
  end

  stim_satcnt #(.W(W_PULSE)) u_ph_cnt (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_i(ph_clr), .en_i(ph_en), .cnt_o(ph_cnt)
  );
  stim_satcnt #(.W(W_PULSE)) u_gap_cnt (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_i(gap_clr), .en_i(gap_en), .cnt_o(gap_cnt)
  );
  stim_satcnt #(.W(W_INTERVAL)) u_int_cnt (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_i(int_clr), .en_i(int_en), .cnt_o(int_cnt)
  );

  assign ph_nxt         = ph_clr ? W_PULSE'(1) : ((&ph_cnt) ? ph_cnt : ph_cnt + W_PULSE'(1));
  assign set_overlength = ph_en && (max_phase_i != '0) && (ph_nxt == max_phase_i);
  assign close          = close_bi | close_mono;
  assign w2             = close_bi ? ph_cnt : '0;
  assign set_imbalance  = close_bi && bal_chk_en_i && (w1_q != ph_cnt);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= M_IDLE; pol_q <= 1'b0; w1_q <= '0; int_lat_q <= '0;
      meas_wa_o <= '0; meas_wc_o <= '0; meas_gap_o <= '0; meas_interval_o <= '0;
      meas_pol_o <= 1'b0; meas_valid_o <= 1'b0; pulse_cnt_o <= '0;
      err_overlap_o <= 1'b0; err_overlength_o <= 1'b0; err_imbalance_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        pol_q     <= anode_en_i;
        int_lat_q <= (state_q == M_IDLE) ? '0 : int_cnt;
      end
      if (w1_ld) w1_q <= ph_cnt;
      meas_valid_o <= close;
      if (close) begin
        meas_pol_o      <= pol_q;
        meas_wa_o       <= pol_q ? w1_q : w2;
        meas_wc_o       <= pol_q ? w2 : w1_q;
        meas_gap_o      <= close_bi ? gap_cnt : '0;
        meas_interval_o <= int_lat_q;
      end
      if (!mon_en_i)  pulse_cnt_o <= '0;
      else if (close) pulse_cnt_o <= pulse_cnt_o + W_NUM'(1);
      err_overlap_o    <= set_overlap    | (err_overlap_o    & ~clear_err_i);
      err_overlength_o <= set_overlength | (err_overlength_o & ~clear_err_i);
      err_imbalance_o  <= set_imbalance  | (err_imbalance_o  & ~clear_err_i);
    end
  end

endmodule
